cpu_mem_responder: RTL and testbench

//  Memory-side responder for the CPU bus (addr_bus/data_bus, mem_read/mem_write).

---
 rtl/cpu_mem_pkg.sv | 38 +++
 rtl/byte_ram.sv | 23 ++
 rtl/cpu_mem_responder.sv | 189 ++++++++++++++++++
 tb/tb_cpu_mem_responder.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// rtl/cpu_mem_pkg.sv - shared types and address decode for the CPU memory responder
package cpu_mem_pkg;

    localparam logic [15:0] ROM_BASE = 16'h0000;
    localparam int          ROM_SIZE = 256;

    typedef enum logic [1:0] {
        REG_ROM   = 2'd0,
        REG_RAM   = 2'd1,
        REG_UNMAP = 2'd2
    } region_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // 17-bit compares so a RAM window ending at 0x10000 does not wrap; ROM wins any overlap.
    function automatic region_e decode_region(input logic [15:0] addr,
                                              input logic [15:0] ram_base,
                                              input int unsigned ram_depth);
        logic [16:0] a_ext;
        logic [16:0] ram_lo;
        logic [16:0] ram_hi;
        a_ext  = {1'b0, addr};
        ram_lo = {1'b0, ram_base};
        ram_hi = ram_lo + 17'(ram_depth);
        if (a_ext < 17'(ROM_BASE) + 17'(ROM_SIZE)) begin
            return REG_ROM;
        end
        if ((a_ext >= ram_lo) && (a_ext < ram_hi)) begin
            return REG_RAM;
        end
        return REG_UNMAP;
    endfunction

endpackage

// File: rtl/byte_ram.sv
// rtl/byte_ram.sv - single-port byte array, synchronous write, combinational read
module byte_ram #(
    parameter  int DEPTH = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/cpu_mem_responder.sv
// rtl/cpu_mem_responder.sv - CPU bus responder: ROM/RAM decode, wait states, ready pulse, ROM load port
module cpu_mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [15:0] RAM_BASE    = 16'h0100,
    parameter int unsigned RAM_DEPTH   = 1024,
    parameter logic [7:0]  UNMAP_DATA  = 8'hFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] addr_bus,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        ready,
    output logic        bus_err,
    input  logic        load_en,
    input  logic [7:0]  load_addr,
    input  logic [7:0]  load_data,
    output logic        busy
);

    localparam int         RAM_AW    = $clog2(RAM_DEPTH);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        ready_q, ready_d;
    logic        bus_err_q, bus_err_d;

    logic              idle;
    logic              load_fire;
    logic              finish;
    logic [15:0]       cur_addr;
    logic              cur_rd;
    logic              cur_wr;
    region_e           cur_region;
    logic              rom_we;
    logic [7:0]        rom_addr;
    logic [7:0]        rom_rdata;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [7:0]        ram_rdata;

    assign idle      = (state_q == ST_IDLE);
    assign load_fire = idle && load_en;

    // With zero wait states the response is formed from the live bus in the latch cycle.
    assign cur_addr   = idle ? addr_bus  : addr_q;
    assign cur_rd     = idle ? mem_read  : rd_q;
    assign cur_wr     = idle ? mem_write : wr_q;
    assign cur_region = decode_region(cur_addr, RAM_BASE, RAM_DEPTH);

    assign rom_we   = load_fire;
    assign rom_addr = load_fire ? load_addr : cur_addr[7:0];
    assign ram_addr = RAM_AW'(cur_addr - RAM_BASE);
    assign ram_we   = (state_q == ST_RESP) && cur_wr && !cur_rd && (cur_region == REG_RAM);

    byte_ram #(
        .DEPTH (ROM_SIZE)
    ) u_rom (
        .clk   (clk),
        .we    (rom_we),
        .addr  (rom_addr),
        .wdata (load_data),
        .rdata (rom_rdata)
    );

    byte_ram #(
        .DEPTH (RAM_DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        rdata_d   = rdata_q;
        ready_d   = 1'b0;
        bus_err_d = 1'b0;
        finish    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!load_en && (mem_read || mem_write)) begin
                    addr_d  = addr_bus;
                    wdata_d = wdata;
                    rd_d    = mem_read;
                    wr_d    = mem_write;
                    if (WAIT_STATES == 0) begin
                        state_d = ST_RESP;
                        finish  = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = ST_RESP;
                    finish  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Response registers load on the edge that enters RESP so ready/rdata/bus_err align.
        if (finish) begin
            ready_d = 1'b1;
            if (cur_rd && cur_wr) begin
                bus_err_d = 1'b1;
            end else begin
                case (cur_region)
                    REG_ROM: begin
                        if (cur_rd) begin
                            rdata_d = rom_rdata;
                        end else begin
                            bus_err_d = 1'b1;
                        end
                    end
                    REG_RAM: begin
                        if (cur_rd) begin
                            rdata_d = ram_rdata;
                        end
                    end
                    default: begin
                        bus_err_d = 1'b1;
                        if (cur_rd) begin
                            rdata_d = UNMAP_DATA;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= 16'h0000;
            wdata_q   <= 8'h00;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            rdata_q   <= 8'h00;
            ready_q   <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            rdata_q   <= rdata_d;
            ready_q   <= ready_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign rdata   = rdata_q;
    assign ready   = ready_q;
    assign bus_err = bus_err_q;
    assign busy    = !idle;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb/tb_cpu_mem_responder.sv - scoreboard bench for cpu_mem_responder with zero and one wait states
module tb_cpu_mem_responder;

    localparam int RD = 1024;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] addr_bus [2];
    logic [1:0]  mem_read;
    logic [1:0]  mem_write;
    logic [7:0]  wdata [2];
    logic [7:0]  rdata [2];
    logic [1:0]  ready;
    logic [1:0]  bus_err;
    logic [1:0]  load_en;
    logic [7:0]  load_addr [2];
    logic [7:0]  load_data [2];
    logic [1:0]  busy;

    always #5 clk = ~clk;

    cpu_mem_responder #(.WAIT_STATES(0), .RAM_BASE(16'h0100), .RAM_DEPTH(RD), .UNMAP_DATA(8'hFF)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .addr_bus(addr_bus[0]), .mem_read(mem_read[0]),
        .mem_write(mem_write[0]), .wdata(wdata[0]), .rdata(rdata[0]), .ready(ready[0]),
        .bus_err(bus_err[0]), .load_en(load_en[0]), .load_addr(load_addr[0]),
        .load_data(load_data[0]), .busy(busy[0])
    );

    cpu_mem_responder #(.WAIT_STATES(1), .RAM_BASE(16'h0100), .RAM_DEPTH(RD), .UNMAP_DATA(8'hFF)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .addr_bus(addr_bus[1]), .mem_read(mem_read[1]),
        .mem_write(mem_write[1]), .wdata(wdata[1]), .rdata(rdata[1]), .ready(ready[1]),
        .bus_err(bus_err[1]), .load_en(load_en[1]), .load_addr(load_addr[1]),
        .load_data(load_data[1]), .busy(busy[1])
    );

    typedef struct {
        logic [7:0] rdata;
        logic       err;
        int         cyc;
        string      tag;
    } exp_t;

    exp_t       sbq0[$];
    exp_t       sbq1[$];
    logic [7:0] rom_m [2][256];
    logic [7:0] ram_m [2][RD];
    logic [7:0] last_rd [2];
    bit   [1:0] at_ready;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int ws(input int d);
        return (d == 0) ? 0 : 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference behaviour straight from the address map: ROM 0x0000-0x00FF, RAM 0x0100.., rest unmapped.
    task automatic model(input int d, input bit rd, input bit wr, input logic [15:0] a,
                         input logic [7:0] wd, output exp_t e);
        int ai;
        ai      = int'(a);
        e.err   = 1'b0;
        e.rdata = last_rd[d];
        if (rd && wr) begin
            e.err = 1'b1;
        end else if (ai < 256) begin
            if (rd) e.rdata = rom_m[d][ai];
            else    e.err   = 1'b1;
        end else if (ai < 256 + RD) begin
            if (rd) e.rdata = ram_m[d][ai - 256];
            else    ram_m[d][ai - 256] = wd;
        end else begin
            e.err = 1'b1;
            if (rd) e.rdata = 8'hFF;
        end
        last_rd[d] = e.rdata;
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (ready[d] === 1'b1) begin
                if ((d == 0 && sbq0.size() == 0) || (d == 1 && sbq1.size() == 0)) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_ready dut%0d: got ready=1, expected no response", d);
                end else begin
                    if (d == 0) e = sbq0.pop_front();
                    else        e = sbq1.pop_front();
                    chk($sformatf("dut%0d %s rdata", d, e.tag), rdata[d], e.rdata);
                    chk($sformatf("dut%0d %s bus_err", d, e.tag), bus_err[d], e.err);
                    chk($sformatf("dut%0d %s latency", d, e.tag), cyc, e.cyc);
                    chk($sformatf("dut%0d %s busy", d, e.tag), busy[d], 1'b1);
                end
            end
        end
    end

    task automatic idle(input int d, input int n);
        mem_read[d]  = 1'b0;
        mem_write[d] = 1'b0;
        load_en[d]   = 1'b0;
        repeat (n) @(negedge clk);
        at_ready[d] = 1'b0;
    endtask

    task automatic load(input int d, input logic [7:0] a, input logic [7:0] v);
        if (at_ready[d]) idle(d, 1);
        load_en[d]   = 1'b1;
        load_addr[d] = a;
        load_data[d] = v;
        rom_m[d][a]  = v;
        @(negedge clk);
        load_en[d] = 1'b0;
    endtask

    // lmode: 0 none, 1 load in the same cycle as the request, 2 load while the request is waiting.
    task automatic do_txn(input int d, input bit rd, input bit wr, input logic [15:0] a,
                          input logic [7:0] wd, input bit keep, input int lmode,
                          input logic [7:0] la, input logic [7:0] ld, input string tag);
        exp_t e;
        int   lat;
        bit   got;
        if (lmode == 1 && at_ready[d]) idle(d, 1);
        lat = 1 + (at_ready[d] ? 1 : 0) + (lmode == 1 ? 1 : 0);
        if (lmode == 1) begin
            load_en[d]   = 1'b1;
            load_addr[d] = la;
            load_data[d] = ld;
            rom_m[d][la] = ld;
        end
        mem_read[d]  = rd;
        mem_write[d] = wr;
        addr_bus[d]  = a;
        wdata[d]     = wd;
        model(d, rd, wr, a, wd, e);
        e.cyc = cyc + lat + ws(d);
        e.tag = tag;
        if (d == 0) sbq0.push_back(e);
        else        sbq1.push_back(e);
        at_ready[d] = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            load_en[d] = 1'b0;
            if (lmode == 2 && i == 0) begin
                load_en[d]   = 1'b1;
                load_addr[d] = la;
                load_data[d] = ld;
            end
            if (ready[d] === 1'b1) got = 1'b1;
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL dut%0d %s timeout: got no ready in 40 cycles, expected ready", d, tag);
        end
        load_en[d] = 1'b0;
        if (!keep) begin
            mem_read[d]  = 1'b0;
            mem_write[d] = 1'b0;
        end
        at_ready[d] = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("dut%0d %s ready", d, tag), ready[d], 1'b0);
            chk($sformatf("dut%0d %s bus_err", d, tag), bus_err[d], 1'b0);
            chk($sformatf("dut%0d %s busy", d, tag), busy[d], 1'b0);
            chk($sformatf("dut%0d %s rdata", d, tag), rdata[d], 8'h00);
        end
    endtask

    initial begin
        logic [15:0] a;
        logic [7:0]  v;
        int          kind;
        int          lmode;
        bit          pk;
        bit          keep;
        reset_n  = 1'b0;
        at_ready = 2'b00;
        for (int d = 0; d < 2; d++) begin
            addr_bus[d] = 16'h0; wdata[d] = 8'h0; load_addr[d] = 8'h0; load_data[d] = 8'h0;
            mem_read[d] = 1'b0; mem_write[d] = 1'b0; load_en[d] = 1'b0; last_rd[d] = 8'h00;
        end
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        @(negedge clk);

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 256; i++) load(d, 8'(i), 8'($urandom));
            for (int i = 0; i < 64; i++)
                do_txn(d, 0, 1, 16'(256 + ((i < 32) ? i : RD - 64 + i)), 8'($urandom), 0, 0, 0, 0, "preload");
            idle(d, 2);
        end

        load(1, 8'h00, 8'hA9);
        do_txn(1, 1, 0, 16'h0000, 0, 0, 0, 0, 0, "t1_rom_read");
        do_txn(1, 0, 1, 16'h0100, 8'h5F, 0, 0, 0, 0, "t2_ram_write");
        do_txn(1, 1, 0, 16'h0100, 0, 0, 0, 0, 0, "t2_ram_read");
        do_txn(1, 0, 1, 16'h0005, 8'h12, 0, 0, 0, 0, "t3_rom_write");
        do_txn(1, 1, 0, 16'h0005, 0, 0, 0, 0, 0, "t3_rom_readback");
        do_txn(1, 1, 0, 16'h8000, 0, 0, 0, 0, 0, "t4_unmapped_read");
        do_txn(1, 1, 1, 16'h0100, 8'hEE, 0, 0, 0, 0, "t4_rd_and_wr");
        do_txn(1, 1, 0, 16'h0100, 0, 0, 0, 0, 0, "t4_ram0_kept");
        do_txn(1, 1, 0, 16'h00FF, 0, 0, 0, 0, 0, "rom_top");
        do_txn(1, 0, 1, 16'h04FF, 8'hC3, 0, 0, 0, 0, "ram_top_write");
        do_txn(1, 1, 0, 16'h04FF, 0, 0, 0, 0, 0, "ram_top_read");
        do_txn(1, 1, 0, 16'h0500, 0, 0, 0, 0, 0, "ram_end_unmapped");
        do_txn(1, 0, 1, 16'hFFFF, 8'h44, 0, 0, 0, 0, "unmapped_write");
        idle(1, 1);
        v = ~rom_m[1][8'h10];
        do_txn(1, 1, 0, 16'h0010, 0, 0, 2, 8'h10, v, "load_in_wait");
        do_txn(1, 1, 0, 16'h0010, 0, 0, 0, 0, 0, "load_dropped");
        do_txn(1, 1, 0, 16'h0020, 0, 0, 1, 8'h20, 8'h5A, "load_wins");
        idle(1, 2);

        do_txn(0, 0, 1, 16'h0100, 8'h31, 0, 0, 0, 0, "t5_wr0");
        do_txn(0, 0, 1, 16'h0101, 8'h32, 0, 0, 0, 0, "t5_wr1");
        do_txn(0, 1, 0, 16'h0100, 0, 1, 0, 0, 0, "t5_b2b_0");
        do_txn(0, 1, 0, 16'h0101, 0, 0, 0, 0, 0, "t5_b2b_1");
        idle(0, 2);

        for (int d = 0; d < 2; d++) begin
            pk = 1'b0;
            for (int k = 0; k < 120; k++) begin
                case ($urandom_range(0, 2))
                    0:       a = 16'($urandom_range(0, 255));
                    1:       a = 16'(256 + (($urandom_range(0, 1) == 1) ? $urandom_range(0, 31) : $urandom_range(RD - 32, RD - 1)));
                    default: a = 16'($urandom_range(16'h0500, 16'hFFFF));
                endcase
                kind  = $urandom_range(0, 99);
                lmode = (!pk && $urandom_range(0, 9) == 0) ? 1 : 0;
                keep  = ($urandom_range(0, 3) == 0);
                if (!pk && $urandom_range(0, 4) == 0) idle(d, $urandom_range(1, 3));
                do_txn(d, kind < 55 || kind >= 90, kind >= 55, a, 8'($urandom), keep, lmode,
                       ($urandom_range(0, 1) == 1) ? a[7:0] : 8'($urandom), 8'($urandom), "random");
                pk = keep;
            end
            idle(d, 2);
        end

        do_txn(1, 0, 1, 16'h0102, 8'h33, 0, 0, 0, 0, "t6_setup");
        idle(1, 1);
        mem_write[1] = 1'b1;
        addr_bus[1]  = 16'h0102;
        wdata[1]     = 8'h77;
        @(negedge clk);
        chk("dut1 t6_busy_in_wait", busy[1], 1'b1);
        reset_n = 1'b0;
        #1;
        chk("dut1 t6_async_idle", busy[1], 1'b0);
        mem_write[1] = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("t6_reset");
        reset_n    = 1'b1;
        last_rd[0] = 8'h00;
        last_rd[1] = 8'h00;
        idle(1, 2);
        idle(0, 1);
        do_txn(1, 1, 0, 16'h0102, 0, 0, 0, 0, 0, "t6_write_lost");
        do_txn(0, 0, 1, 16'h0103, 8'h9A, 0, 0, 0, 0, "rdata_hold_after_reset");
        idle(1, 3);
        idle(0, 1);

        chk("dut0 sb_drained", sbq0.size(), 0);
        chk("dut1 sb_drained", sbq1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no end of test, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

endmodule
